// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix scanner: walks an active-low column, synchronises the rows, debounces
// press and release on dwell ticks and emits one encoded event per accepted press.
module keypad_scan_ctrl #(
  parameter int NUM_COLS    = 4,
  parameter int NUM_ROWS    = 4,
  parameter int DWELL       = 1000,
  parameter int DEBOUNCE    = 4,
  parameter int SYNC_STAGES = 2,
  localparam int COL_W  = $clog2(NUM_COLS),
  localparam int CODE_W = $clog2(NUM_COLS * NUM_ROWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_en,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic [COL_W-1:0]    col_idx,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DBC_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_HELD, ST_REL} state_t;

  state_t              state, state_nxt;
  logic [NUM_ROWS-1:0] sync_p [SYNC_STAGES];
  logic [NUM_ROWS-1:0] rs_n;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DBC_W-1:0]    dbc, dbc_nxt, dbc_inc;
  logic [ROW_W-1:0]    row_sel, row_nxt, low_row;
  logic [COL_W-1:0]    col_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic                valid_nxt, held_nxt, multi_nxt;
  logic                tick, any_low, multi_low, accept, leave;

  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
    return (c == COL_W'(NUM_COLS - 1)) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    return CODE_W'(r) * CODE_W'(NUM_COLS) + CODE_W'(c);
  endfunction

  assign cols_n  = scan_en ? ~(NUM_COLS'(1) << col_idx) : '1;
  assign rs_n    = sync_p[SYNC_STAGES-1];
  assign tick    = (cnt == CNT_W'(DWELL - 1));
  assign dbc_inc = dbc + 1'b1;

  // row synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '1;
    end else begin
      sync_p[0] <= rows_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  // lowest pressed row wins; a second low row flags a multi-key condition
  always_comb begin
    any_low   = 1'b0;
    multi_low = 1'b0;
    low_row   = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!rs_n[i]) begin
        if (any_low) multi_low = 1'b1;
        else         low_row   = ROW_W'(i);
        any_low = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? '0 : cnt + 1'b1;
    dbc_nxt   = dbc;
    row_nxt   = row_sel;
    col_nxt   = col_idx;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    multi_nxt = multi_key;
    accept    = 1'b0;
    leave     = 1'b0;
    if (!scan_en) begin
      state_nxt = ST_SCAN;
      cnt_nxt   = '0;
      dbc_nxt   = '0;
      col_nxt   = '0;
      held_nxt  = 1'b0;
      multi_nxt = 1'b0;
    end else if (tick) begin
      unique case (state)
        ST_SCAN: begin
          if (!any_low) begin
            col_nxt = col_inc(col_idx);
          end else begin
            row_nxt   = low_row;
            multi_nxt = multi_low;
            dbc_nxt   = DBC_W'(1);
            if (DEBOUNCE == 1) accept = 1'b1;
            else               state_nxt = ST_DEB;
          end
        end
        ST_DEB: begin
          if (!rs_n[row_sel]) begin
            dbc_nxt = dbc_inc;
            if (dbc_inc == DBC_W'(DEBOUNCE)) accept = 1'b1;
          end else begin
            state_nxt = ST_SCAN;
            multi_nxt = 1'b0;
            col_nxt   = col_inc(col_idx);
          end
        end
        ST_HELD: begin
          if (rs_n[row_sel]) begin
            dbc_nxt = DBC_W'(1);
            if (DEBOUNCE == 1) leave = 1'b1;
            else               state_nxt = ST_REL;
          end
        end
        ST_REL: begin
          if (rs_n[row_sel]) begin
            dbc_nxt = dbc_inc;
            if (dbc_inc == DBC_W'(DEBOUNCE)) leave = 1'b1;
          end else begin
            state_nxt = ST_HELD;
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
      if (accept) begin
        state_nxt = ST_HELD;
        code_nxt  = encode(row_nxt, col_idx);
        valid_nxt = 1'b1;
        held_nxt  = 1'b1;
      end
      if (leave) begin
        state_nxt = ST_SCAN;
        held_nxt  = 1'b0;
        multi_nxt = 1'b0;
        col_nxt   = col_inc(col_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SCAN;
      cnt       <= '0;
      dbc       <= '0;
      row_sel   <= '0;
      col_idx   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dbc       <= dbc_nxt;
      row_sel   <= row_nxt;
      col_idx   <= col_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
      multi_key <= multi_nxt;
    end
  end

endmodule
